// File: rtl/hazard_ctrl_unit.sv
// Hazard control for a five-stage pipeline: operand forwarding, load-use and
// multi-cycle load stalls, branch flushes, and saturating stall/flush counters.
module hazard_ctrl_unit #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic              MemReadE,
   input  logic              MemReadM,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              PCSrcE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int CW = ($clog2(LOAD_LAT) < 1) ? 1 : $clog2(LOAD_LAT);
   localparam logic [CW-1:0]    CNT_LOAD = CW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CNT_W-1:0] CTR_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CTR_MAX  = {CNT_W{1'b1}};

   typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

   state_t          state_r, state_nxt_s;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic            mem_stall_s;
   logic            lw_stall_s;
   logic [1:0]      fwd_a_s, fwd_b_s;
   logic            stall_f_s, stall_d_s, stall_e_s, stall_m_s;
   logic            flush_d_s, flush_e_s, flush_w_s;
   logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

   // M-stage match wins over W-stage match; register x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic [REG_AW-1:0] rd_w,
                                          input logic              we_m,
                                          input logic              we_w);
      logic [1:0] sel;
      if (we_m && (rd_m != '0) && (rd_m == src)) begin
         sel = 2'b10;
      end else if (we_w && (rd_w != '0) && (rd_w == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign lw_stall_s = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // State and wait-counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Load-latency FSM: the first M cycle of a load stalls and arms the counter.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      mem_stall_s = 1'b0;
      case (state_r)
         RUN: begin
            if (MemReadM && (LOAD_LAT > 1)) begin
               mem_stall_s = 1'b1;
               cnt_nxt_s   = CNT_LOAD;
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         WAIT: begin
            if (cnt_r != '0) begin
               mem_stall_s = 1'b1;
               cnt_nxt_s   = cnt_r - CNT_ONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Stall/flush/forward decode; everything is forced low while reset is held.
   always_comb begin
      fwd_a_s   = 2'b00;
      fwd_b_s   = 2'b00;
      stall_f_s = 1'b0;
      stall_d_s = 1'b0;
      stall_e_s = 1'b0;
      stall_m_s = 1'b0;
      flush_d_s = 1'b0;
      flush_e_s = 1'b0;
      flush_w_s = 1'b0;
      if (rst) begin
         fwd_a_s = 2'b00;
      end else if (mem_stall_s) begin
         fwd_a_s   = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
         fwd_b_s   = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
         stall_f_s = 1'b1;
         stall_d_s = 1'b1;
         stall_e_s = 1'b1;
         stall_m_s = 1'b1;
         flush_w_s = 1'b1;
      end else begin
         fwd_a_s   = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
         fwd_b_s   = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
         stall_f_s = lw_stall_s;
         stall_d_s = lw_stall_s;
         flush_d_s = PCSrcE;
         flush_e_s = lw_stall_s || PCSrcE;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (stall_f_s && (stall_cnt_r != CTR_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CTR_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush_d_s && (flush_cnt_r != CTR_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CTR_ONE;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign ForwardAE = fwd_a_s;
   assign ForwardBE = fwd_b_s;
   assign StallF    = stall_f_s;
   assign StallD    = stall_d_s;
   assign StallE    = stall_e_s;
   assign StallM    = stall_m_s;
   assign FlushD    = flush_d_s;
   assign FlushE    = flush_e_s;
   assign FlushW    = flush_w_s;
   assign busy      = (state_r == WAIT);
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule
